// File: rtl/snake_pkg.sv
// Shared encodings for the snake sequencer and mover: directions, FSM states, playfield size.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package snake_pkg;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam int WIDTH  = 32;
    localparam int HEIGHT = 24;
    localparam int CELLS  = WIDTH * HEIGHT;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_EVAL = 3'd2,
        ST_FOOD = 3'd3,
        ST_DEAD = 3'd4
    } state_t;

    // Opposite directions share the axis bit and differ in the sign bit.
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_lfsr.sv
// 10-bit Fibonacci LFSR (taps 10,7) that advances one position per enabled cycle.
// Latency: value reflects the advance on the clock after en.
// Backpressure: none; en simply holds the state when low.
module snake_lfsr #(
    parameter logic [9:0] seed = 10'h2A5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] value
);

    logic [9:0] lfsr_q;
    logic [9:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/snake_ctrl.sv
// Snake game sequencer: step strobe, direction filter, length/score, food placement FSM.
// Latency: step every tick_div RUN cycles; mover results sampled 2 cycles after step.
// Backpressure: none; FOOD retries a new LFSR candidate each cycle until one is accepted.
module snake_ctrl
    import snake_pkg::*;
#(
    parameter int         max_len   = 16,
    parameter int         num_len   = 10,
    parameter int         init_len  = 5,
    parameter int         tick_div  = 25000000,
    parameter int         food_init = 100,
    parameter logic [9:0] lfsr_seed = 10'h2A5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               dir_valid,
    input  logic [1:0]         dir_req,
    input  logic [num_len-1:0] head_pos,
    input  logic               should_stop,
    output logic               step,
    output logic [1:0]         di,
    output logic [3:0]         len,
    output logic [num_len-1:0] food_pos,
    output logic [7:0]         score,
    output logic [2:0]         game_state
);

    localparam int TW = (tick_div > 1) ? $clog2(tick_div) : 1;

    state_t             state_q, state_d;
    logic               step_q, step_d;
    logic [1:0]         di_q, di_d;
    logic [1:0]         pend_q, pend_d;
    logic [3:0]         len_q, len_d;
    logic [num_len-1:0] food_q, food_d;
    logic [7:0]         score_q, score_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic               settle_q, settle_d;

    logic               lfsr_en;
    logic [9:0]         lfsr_val;
    logic               food_ok;

    snake_lfsr #(
        .seed (lfsr_seed)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .value (lfsr_val)
    );

    assign food_ok = (lfsr_val < 10'(CELLS)) && (num_len'(lfsr_val) != head_pos);

    always_comb begin
        state_d  = state_q;
        step_d   = 1'b0;
        di_d     = di_q;
        pend_d   = pend_q;
        len_d    = len_q;
        food_d   = food_q;
        score_d  = score_q;
        tick_d   = tick_q;
        settle_d = settle_q;
        lfsr_en  = 1'b0;

        if (dir_valid && (state_q == ST_RUN || state_q == ST_EVAL || state_q == ST_FOOD)
                && !is_reverse(dir_req, di_q)) begin
            pend_d = dir_req;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tick_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tick_q == TW'(tick_div - 1)) begin
                    tick_d   = '0;
                    step_d   = 1'b1;
                    di_d     = pend_q;
                    settle_d = 1'b0;
                    state_d  = ST_EVAL;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            // First EVAL cycle overlaps the step pulse; the mover head is trusted on the second.
            ST_EVAL: begin
                if (!settle_q) begin
                    settle_d = 1'b1;
                end else begin
                    settle_d = 1'b0;
                    if (should_stop) begin
                        state_d = ST_DEAD;
                    end else if (head_pos == food_q) begin
                        if (len_q < 4'(max_len - 1)) begin
                            len_d = len_q + 4'd1;
                        end
                        if (score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                        end
                        state_d = ST_FOOD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FOOD: begin
                lfsr_en = 1'b1;
                if (food_ok) begin
                    food_d  = num_len'(lfsr_val);
                    state_d = ST_RUN;
                end
            end
            ST_DEAD: begin
                if (start) begin
                    di_d    = DIR_RIGHT;
                    pend_d  = DIR_RIGHT;
                    len_d   = 4'(init_len);
                    food_d  = num_len'(food_init);
                    score_d = '0;
                    tick_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            step_q   <= 1'b0;
            di_q     <= DIR_RIGHT;
            pend_q   <= DIR_RIGHT;
            len_q    <= 4'(init_len);
            food_q   <= num_len'(food_init);
            score_q  <= '0;
            tick_q   <= '0;
            settle_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            di_q     <= di_d;
            pend_q   <= pend_d;
            len_q    <= len_d;
            food_q   <= food_d;
            score_q  <= score_d;
            tick_q   <= tick_d;
            settle_q <= settle_d;
        end
    end

    assign step       = step_q;
    assign di         = di_q;
    assign len        = len_q;
    assign food_pos   = food_q;
    assign score      = score_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// Directed-plus-random bench for snake_ctrl with a game-level reference model.
module tb_snake_ctrl;
    import snake_pkg::*;

    localparam int TICK = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_req = 2'b00;
    logic [9:0] head_pos = 10'd0;
    logic       should_stop = 1'b0;
    logic       step;
    logic [1:0] di;
    logic [3:0] len;
    logic [9:0] food_pos;
    logic [7:0] score;
    logic [2:0] game_state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: game-level quantities only.
    int m_di, m_pend, m_len, m_score, m_food, m_lfsr;

    snake_ctrl #(
        .tick_div (TICK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dir_valid   (dir_valid),
        .dir_req     (dir_req),
        .head_pos    (head_pos),
        .should_stop (should_stop),
        .step        (step),
        .di          (di),
        .len         (len),
        .food_pos    (food_pos),
        .score       (score),
        .game_state  (game_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit rev(input int a, input int b);
        return (a == 0 && b == 1) || (a == 1 && b == 0) || (a == 2 && b == 3) || (a == 3 && b == 2);
    endfunction

    // x^10 + x^7 feedback: shift left, new LSB = bit9 xor bit6.
    function automatic int adv(input int v);
        return ((v * 2) % 1024) + (((v / 512) ^ (v / 64)) % 2);
    endfunction

    task automatic model_reset(input bit lfsr_too);
        m_di = 1; m_pend = 1; m_len = 5; m_score = 0; m_food = 100;
        if (lfsr_too) m_lfsr = 'h2A5;
    endtask

    task automatic check_outs(input string tag, input int st);
        chk({tag, "_state"}, game_state, st);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_di"}, di, m_di);
        chk({tag, "_len"}, len, m_len);
        chk({tag, "_food"}, food_pos, m_food);
        chk({tag, "_score"}, score, m_score);
    endtask

    task automatic pick_nonfood(output logic [9:0] h);
        do h = 10'($urandom_range(0, 767)); while (int'(h) == m_food);
    endtask

    // Entered with the DUT freshly in RUN; plays one step through EVAL (and FOOD).
    task automatic run_step(input logic [9:0] head, input bit stop, input bit do_dir,
                            input logic [1:0] dreq, input bit noise);
        int cyc;
        int k;
        int cand;
        int exp_st;
        if (do_dir) begin
            dir_valid = 1'b1;
            dir_req   = dreq;
            if (!rev(dreq, m_di)) m_pend = dreq;
        end
        if (noise) start = 1'b1;
        cyc = 0;
        do begin
            tick();
            dir_valid = 1'b0;
            start     = 1'b0;
            cyc++;
        end while (step !== 1'b1 && cyc < 100);
        chk("step_spacing", cyc, TICK);
        m_di = m_pend;
        chk("step_di", di, m_di);
        chk("step_state", game_state, ST_EVAL);
        head_pos    = head;
        should_stop = stop;
        if (noise) begin
            dir_valid = 1'b1;
            dir_req   = 2'($urandom_range(0, 3));
            if (!rev(dir_req, m_di)) m_pend = dir_req;
        end
        tick();
        dir_valid = 1'b0;
        chk("step_width", step, 0);
        chk("eval_settle", game_state, ST_EVAL);
        tick();
        if (stop) begin
            exp_st = ST_DEAD;
        end else if (int'(head) == m_food) begin
            m_len   = (m_len < 15) ? m_len + 1 : 15;
            m_score = (m_score < 255) ? m_score + 1 : 255;
            exp_st  = ST_FOOD;
        end else begin
            exp_st = ST_RUN;
        end
        chk("eval_result", game_state, exp_st);
        if (exp_st == ST_FOOD) begin
            k = 0;
            do begin
                k++;
                cand   = m_lfsr;
                m_lfsr = adv(m_lfsr);
            end while (!(cand < 768 && cand != int'(head)));
            m_food = cand;
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (game_state === ST_FOOD && cyc < 2000);
            chk("food_dwell", cyc, k);
            chk("food_exit", game_state, ST_RUN);
        end
        chk("len", len, m_len);
        chk("score", score, m_score);
        chk("food_pos", food_pos, m_food);
        chk("di_hold", di, m_di);
        should_stop = 1'b0;
    endtask

    initial begin
        logic [9:0] h;
        int  cyc;
        bit  saw_step;

        // Reset values
        rst_n = 1'b0;
        repeat (3) tick();
        model_reset(1);
        check_outs("reset", ST_IDLE);
        rst_n = 1'b1;
        tick();
        chk("idle_hold", game_state, ST_IDLE);

        // dir_valid in IDLE must not reach the pending register
        dir_valid = 1'b1; dir_req = DIR_UP;
        tick();
        dir_valid = 1'b0;

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_run", game_state, ST_RUN);

        // Reversal dropped, then a perpendicular turn commits
        pick_nonfood(h);
        run_step(h, 1'b0, 1'b1, DIR_LEFT, 1'b0);
        chk("rev_dropped", di, DIR_RIGHT);
        pick_nonfood(h);
        run_step(h, 1'b0, 1'b1, DIR_UP, 1'b0);
        chk("turn_up", di, DIR_UP);

        // First capture from the seed sequence
        run_step(10'(m_food), 1'b0, 1'b0, 2'b00, 1'b0);
        chk("cap_food_seed", food_pos, 10'h2A5);
        chk("cap_food_range", food_pos < 10'd768, 1);
        chk("cap_food_moved", food_pos != 10'd100, 1);
        chk("cap_len", len, 6);
        chk("cap_score", score, 1);

        // Random play with 11 more captures: length saturates, score keeps counting
        for (int i = 0; i < 11; i++) begin
            pick_nonfood(h);
            run_step(h, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b1);
            run_step(10'(m_food), 1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b1);
        end
        chk("len_sat", len, 15);
        chk("score_12", score, 12);

        // Wall: DEAD, frozen, no step
        pick_nonfood(h);
        run_step(h, 1'b1, 1'b0, 2'b00, 1'b0);
        saw_step = 1'b0;
        repeat (50) begin
            tick();
            if (step !== 1'b0) saw_step = 1'b1;
        end
        chk("dead_no_step", saw_step, 0);
        check_outs("dead", ST_DEAD);

        start = 1'b1;
        tick();
        start = 1'b0;
        model_reset(0);
        check_outs("restart", ST_IDLE);

        // IDLE ignores dir; LFSR continues across restart
        dir_valid = 1'b1; dir_req = DIR_DOWN;
        tick();
        dir_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        pick_nonfood(h);
        run_step(h, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("idle_dir_ignored", di, DIR_RIGHT);
        run_step(10'(m_food), 1'b0, 1'b0, 2'b00, 1'b0);

        // Async reset while in FOOD
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (step !== 1'b1 && cyc < 100);
        chk("pre_arst_spacing", cyc, TICK);
        head_pos = 10'(m_food);
        tick();
        tick();
        chk("pre_arst_food", game_state, ST_FOOD);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset(1);
        check_outs("arst", ST_IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst_idle", game_state, ST_IDLE);

        // LFSR back at seed after reset
        start = 1'b1;
        tick();
        start = 1'b0;
        run_step(10'(m_food), 1'b0, 1'b0, 2'b00, 1'b0);
        chk("arst_seed_food", food_pos, 10'h2A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
